spmv_perf_timer: RTL and testbench

Multi-channel cycle profiler for the SpMV calculation kernel: each of NUM_CH independent channels measures clock cycles between a rising edge on its begin strobe and a rising edge on its end strobe. Per channel it keeps total cycles (single-shot or accumulating), last and maximum interval length, and completed-interval count, all saturating. It sits beside the SpMV kernel control logic and feeds the host-visible status registers in the 250 MHz box.

---
 rtl/spmv_perf_timer.sv | 85 ++++++++
 tb/tb_spmv_perf_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_perf_timer.sv
// spmv_perf_timer: per-channel begin/end cycle profiler with saturating
// total/last/max/interval statistics.
module spmv_perf_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 64,
  parameter int EVT_W = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       begin_sig,
  input  logic [NUM_CH-1:0]       end_sig,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       accum_mode,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done_pulse,
  output logic [NUM_CH-1:0]       sat,
  output logic [NUM_CH*CNT_W-1:0] total_cycles,
  output logic [NUM_CH*CNT_W-1:0] last_cycles,
  output logic [NUM_CH*CNT_W-1:0] max_cycles,
  output logic [NUM_CH*EVT_W-1:0] interval_cnt
);
  logic [NUM_CH-1:0] begin_ff, end_ff, rise_b, rise_e;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      begin_ff <= '0;
      end_ff   <= '0;
    end else begin
      begin_ff <= begin_sig;
      end_ff   <= end_sig;
    end
  assign rise_b = begin_sig & ~begin_ff;
  assign rise_e = end_sig & ~end_ff;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cur, total, last, max_len, len;
    logic [EVT_W-1:0] cnt;
    logic run, dp, st;
    // interval length including the end edge, held at all-ones
    assign len = &cur ? cur : cur + CNT_W'(1);
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        cur     <= '0;
        total   <= '0;
        last    <= '0;
        max_len <= '0;
        cnt     <= '0;
        run     <= 1'b0;
        dp      <= 1'b0;
        st      <= 1'b0;
      end else begin
        dp <= 1'b0;
        if (clr[i]) begin
          cur     <= '0;
          total   <= '0;
          last    <= '0;
          max_len <= '0;
          cnt     <= '0;
          run     <= 1'b0;
          st      <= 1'b0;
        end else if (run && rise_e[i]) begin
          last    <= len;
          max_len <= len > max_len ? len : max_len;
          cnt     <= &cnt ? cnt : cnt + EVT_W'(1);
          total   <= &total ? total : total + CNT_W'(1);
          run     <= 1'b0;
          dp      <= 1'b1;
          st      <= st | (&cur) | (&total) | (&cnt);
        end else if (!run && rise_b[i]) begin
          run <= 1'b1;
          cur <= '0;
          if (!accum_mode[i]) total <= '0;
        end else if (run) begin
          cur   <= &cur ? cur : cur + CNT_W'(1);
          total <= &total ? total : total + CNT_W'(1);
          st    <= st | (&cur) | (&total);
        end
      end
    assign busy[i]       = run;
    assign done_pulse[i] = dp;
    assign sat[i]        = st;
    assign total_cycles[i*CNT_W +: CNT_W] = total;
    assign last_cycles[i*CNT_W +: CNT_W]  = last;
    assign max_cycles[i*CNT_W +: CNT_W]   = max_len;
    assign interval_cnt[i*EVT_W +: EVT_W] = cnt;
  end
endmodule

// File: tb/tb_spmv_perf_timer.sv
// tb_spmv_perf_timer: directed + random check of spmv_perf_timer against a
// timestamp-based interval model (units 0..3 wide DUT, unit 4 narrow DUT).
module tb_spmv_perf_timer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [4:0] bv = '0, ev = '0, cv = '0, av = '0;
  logic [3:0] busy, done_pulse, sat;
  logic [63:0] total_cycles, last_cycles, max_cycles;
  logic [31:0] interval_cnt;
  logic [0:0] sbusy, sdone, ssat;
  logic [3:0] stotal, slast, smax;
  logic [2:0] scnt;
  int checks = 0, failures = 0;

  spmv_perf_timer #(.NUM_CH(4), .CNT_W(16), .EVT_W(8)) dut (
    .clk(clk), .rstn(rstn), .begin_sig(bv[3:0]), .end_sig(ev[3:0]), .clr(cv[3:0]),
    .accum_mode(av[3:0]), .busy(busy), .done_pulse(done_pulse), .sat(sat),
    .total_cycles(total_cycles), .last_cycles(last_cycles), .max_cycles(max_cycles),
    .interval_cnt(interval_cnt));

  spmv_perf_timer #(.NUM_CH(1), .CNT_W(4), .EVT_W(3)) dut_s (
    .clk(clk), .rstn(rstn), .begin_sig(bv[4]), .end_sig(ev[4]), .clr(cv[4]),
    .accum_mode(av[4]), .busy(sbusy), .done_pulse(sdone), .sat(ssat),
    .total_cycles(stotal), .last_cycles(slast), .max_cycles(smax), .interval_cnt(scnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: each interval is a start timestamp; statistics follow from elapsed edges
  longint t = 0;
  bit pb[5], pe[5], m_run[5], m_done[5], m_sat[5];
  longint m_start[5], m_base[5], m_total[5], m_last[5], m_max[5], m_cnt[5];

  function automatic longint lmin(input longint a, input longint b);
    return a < b ? a : b;
  endfunction

  always @(negedge rstn)
    for (int u = 0; u < 5; u++) begin
      pb[u] = 0; pe[u] = 0; m_run[u] = 0; m_done[u] = 0; m_sat[u] = 0;
      m_total[u] = 0; m_last[u] = 0; m_max[u] = 0; m_cnt[u] = 0;
    end

  always @(posedge clk) if (rstn) begin
    longint mx, ex, k;
    bit rb, re;
    t++;
    for (int u = 0; u < 5; u++) begin
      mx = u == 4 ? 15 : 65535;
      ex = u == 4 ? 7 : 255;
      rb = bv[u] & !pb[u];
      re = ev[u] & !pe[u];
      pb[u] = bv[u];
      pe[u] = ev[u];
      m_done[u] = 0;
      if (cv[u]) begin
        m_run[u] = 0; m_sat[u] = 0;
        m_total[u] = 0; m_last[u] = 0; m_max[u] = 0; m_cnt[u] = 0;
      end else if (m_run[u] && re) begin
        k = t - m_start[u];
        m_last[u] = lmin(k, mx);
        if (m_last[u] > m_max[u]) m_max[u] = m_last[u];
        if (m_cnt[u] == ex) m_sat[u] = 1; else m_cnt[u]++;
        if (m_base[u] + k > mx) m_sat[u] = 1;
        m_total[u] = lmin(m_base[u] + k, mx);
        m_run[u] = 0;
        m_done[u] = 1;
      end else if (!m_run[u] && rb) begin
        m_run[u] = 1;
        m_start[u] = t;
        m_base[u] = av[u] ? m_total[u] : 0;
        m_total[u] = m_base[u];
      end else if (m_run[u]) begin
        k = t - m_start[u];
        if (m_base[u] + k > mx) m_sat[u] = 1;
        m_total[u] = lmin(m_base[u] + k, mx);
      end
    end
  end

  task automatic cmp_unit(input int u, input logic b, input logic d, input logic s,
                          input logic [63:0] tot, input logic [63:0] la,
                          input logic [63:0] mx, input logic [63:0] cn);
    check($sformatf("u%0d_busy", u), 64'(b), 64'(m_run[u]));
    check($sformatf("u%0d_done", u), 64'(d), 64'(m_done[u]));
    check($sformatf("u%0d_sat", u), 64'(s), 64'(m_sat[u]));
    check($sformatf("u%0d_total", u), tot, m_total[u]);
    check($sformatf("u%0d_last", u), la, m_last[u]);
    check($sformatf("u%0d_max", u), mx, m_max[u]);
    check($sformatf("u%0d_cnt", u), cn, m_cnt[u]);
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 4; u++)
      cmp_unit(u, busy[u], done_pulse[u], sat[u], 64'(total_cycles[u*16 +: 16]),
               64'(last_cycles[u*16 +: 16]), 64'(max_cycles[u*16 +: 16]),
               64'(interval_cnt[u*8 +: 8]));
    cmp_unit(4, sbusy[0], sdone[0], ssat[0], 64'(stotal), 64'(slast), 64'(smax), 64'(scnt));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic interval(input int u, input int k);
    @(negedge clk);
    bv[u] = 1'b1;
    repeat (k) @(negedge clk);
    ev[u] = 1'b1;
    @(negedge clk);
    bv[u] = 1'b0;
    ev[u] = 1'b0;
  endtask

  task automatic clear_all();
    @(negedge clk);
    bv = '0; ev = '0; cv = '1;
    @(negedge clk);
    cv = '0;
  endtask

  initial begin
    #23 rstn = 1'b1;
    cyc(2);
    check("reset_total", total_cycles, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    // single interval, restart mode
    interval(0, 15);
    check("t1_done", 64'(done_pulse[0]), 64'd1);
    check("t1_last", 64'(last_cycles[15:0]), 64'd15);
    check("t1_total", 64'(total_cycles[15:0]), 64'd15);
    check("t1_max", 64'(max_cycles[15:0]), 64'd15);
    check("t1_cnt", 64'(interval_cnt[7:0]), 64'd1);
    // accumulate vs restart
    av[1] = 1'b1;
    interval(1, 5);
    interval(1, 8);
    check("t2_total_acc", 64'(total_cycles[31:16]), 64'd13);
    check("t2_last", 64'(last_cycles[31:16]), 64'd8);
    check("t2_max", 64'(max_cycles[31:16]), 64'd8);
    check("t2_cnt", 64'(interval_cnt[15:8]), 64'd2);
    @(negedge clk); cv[1] = 1'b1; av[1] = 1'b0;
    @(negedge clk); cv[1] = 1'b0;
    interval(1, 5);
    interval(1, 8);
    check("t2_total_rst", 64'(total_cycles[31:16]), 64'd8);
    check("t2_cnt_rst", 64'(interval_cnt[15:8]), 64'd2);
    // simultaneous begin/end in IDLE, begin re-rise during RUN
    @(negedge clk); bv[2] = 1'b1; ev[2] = 1'b1;
    @(negedge clk); ev[2] = 1'b0; bv[2] = 1'b0;
    check("t3_busy", 64'(busy[2]), 64'd1);
    @(negedge clk); bv[2] = 1'b1;
    @(negedge clk); ev[2] = 1'b1;
    @(negedge clk);
    check("t3_done", 64'(done_pulse[2]), 64'd1);
    check("t3_last", 64'(last_cycles[47:32]), 64'd3);
    bv[2] = 1'b0; ev[2] = 1'b0;
    // saturation on the narrow instance
    interval(4, 20);
    check("t4_total", 64'(stotal), 64'd15);
    check("t4_last", 64'(slast), 64'd15);
    check("t4_sat", 64'(ssat), 64'd1);
    @(negedge clk); cv[4] = 1'b1;
    @(negedge clk); cv[4] = 1'b0;
    check("t4_clr_total", 64'(stotal), 64'd0);
    check("t4_clr_sat", 64'(ssat), 64'd0);
    repeat (8) interval(4, 1);
    check("t4_cnt_sat", 64'(scnt), 64'd7);
    check("t4_cnt_flag", 64'(ssat), 64'd1);
    check("t4_last_min", 64'(slast), 64'd1);
    // clr beats a simultaneous end strobe mid-interval
    @(negedge clk); bv[3] = 1'b1;
    cyc(4);
    cv[3] = 1'b1; ev[3] = 1'b1;
    @(negedge clk);
    check("t5_clr_busy", 64'(busy[3]), 64'd0);
    check("t5_clr_done", 64'(done_pulse[3]), 64'd0);
    cv[3] = 1'b0; ev[3] = 1'b0; bv[3] = 1'b0;
    // async reset mid-interval, off the clock edge
    @(negedge clk); bv[0] = 1'b1;
    cyc(5);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_total", total_cycles, 64'd0);
    check("t5_rst_last", last_cycles, 64'd0);
    check("t5_rst_cnt", 64'(interval_cnt), 64'd0);
    #3 rstn = 1'b1;
    clear_all();
    // overlapping intervals on all wide channels
    fork
      interval(0, 7);
      begin cyc(2); interval(1, 12); end
      begin cyc(4); interval(2, 1); end
      interval(3, 30);
    join
    check("t6_last0", 64'(last_cycles[15:0]), 64'd7);
    check("t6_last1", 64'(last_cycles[31:16]), 64'd12);
    check("t6_last2", 64'(last_cycles[47:32]), 64'd1);
    check("t6_last3", 64'(last_cycles[63:48]), 64'd30);
    // random strobes, clears and mode changes
    repeat (2000) begin
      @(negedge clk);
      for (int u = 0; u < 5; u++) begin
        if ($urandom_range(0, 3) == 0) bv[u] = ~bv[u];
        if ($urandom_range(0, 5) == 0) ev[u] = ~ev[u];
        cv[u] = $urandom_range(0, 99) == 0;
        if ($urandom_range(0, 15) == 0) av[u] = 1'($urandom_range(0, 1));
      end
    end
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
